// File: rtl/dtu_route_tagger.sv
// rtl/dtu_route_tagger.sv - per-packet route tagger with 2-entry skid buffer; DTU_ROUTE_STATS_EN enables counters
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef PID_BITS
`define PID_BITS 4
`endif

module dtu_route_tagger #(
    parameter int DATA_BITS = `AXI_DATA_BITS,
    parameter int ID_BITS   = `PID_BITS,
    parameter int N_DEST    = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   cfg_route_valid,
    input  logic [7:0]             cfg_route,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [DATA_BITS-1:0]   s_tdata,
    input  logic [DATA_BITS/8-1:0] s_tkeep,
    input  logic                   s_tlast,
    input  logic [ID_BITS-1:0]     s_tid,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [DATA_BITS-1:0]   m_tdata,
    output logic [DATA_BITS/8-1:0] m_tkeep,
    output logic                   m_tlast,
    output logic [ID_BITS-1:0]     m_tid,
    output logic [7:0]             m_tdest,
    output logic [31:0]            pkt_cnt,
    output logic [15:0]            drop_cnt,
    output logic                   route_err
);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t                 r_state;
    logic [7:0]             r_cur_route;
    logic [7:0]             r_pkt_route;
    logic                   r_rdy_en;
    logic                   r_m_valid;
    logic [DATA_BITS-1:0]   r_m_data;
    logic [DATA_BITS/8-1:0] r_m_keep;
    logic                   r_m_last;
    logic [ID_BITS-1:0]     r_m_id;
    logic [7:0]             r_m_dest;
    logic                   r_sk_valid;
    logic [DATA_BITS-1:0]   r_sk_data;
    logic [DATA_BITS/8-1:0] r_sk_keep;
    logic                   r_sk_last;
    logic [ID_BITS-1:0]     r_sk_id;
    logic [7:0]             r_sk_dest;

    logic       w_route_ok;
    logic       w_drop_beat;
    logic       w_s_ready;
    logic       w_acc;
    logic       w_push;
    logic       w_pop;
    logic [7:0] w_dest;

    // A first beat takes the live route; later beats reuse the latched one.
    assign w_route_ok  = r_cur_route < 8'(N_DEST);
    assign w_drop_beat = (r_state == DROP) || ((r_state == IDLE) && !w_route_ok);
    assign w_s_ready   = r_rdy_en && (w_drop_beat || !(r_m_valid && r_sk_valid));
    assign w_acc       = s_tvalid && w_s_ready;
    assign w_push      = w_acc && !w_drop_beat;
    assign w_pop       = r_m_valid && m_tready;
    assign w_dest      = (r_state == IDLE) ? r_cur_route : r_pkt_route;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_cur_route <= 8'd0;
            r_pkt_route <= 8'd0;
            r_rdy_en    <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (cfg_route_valid)
                r_cur_route <= cfg_route;
            if (w_acc) begin
                case (r_state)
                    IDLE: begin
                        r_pkt_route <= r_cur_route;
                        if (!s_tlast)
                            r_state <= w_route_ok ? PASS : DROP;
                    end
                    default: if (s_tlast) r_state <= IDLE;
                endcase
            end
        end
    end

    // Output register is entry 0; the skid register only fills while stalled.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_keep   <= '0;
            r_m_last   <= 1'b0;
            r_m_id     <= '0;
            r_m_dest   <= 8'd0;
            r_sk_valid <= 1'b0;
            r_sk_data  <= '0;
            r_sk_keep  <= '0;
            r_sk_last  <= 1'b0;
            r_sk_id    <= '0;
            r_sk_dest  <= 8'd0;
        end else if (w_pop && r_sk_valid) begin
            r_m_data   <= r_sk_data;
            r_m_keep   <= r_sk_keep;
            r_m_last   <= r_sk_last;
            r_m_id     <= r_sk_id;
            r_m_dest   <= r_sk_dest;
            r_sk_valid <= 1'b0;
        end else if (w_push && (w_pop || !r_m_valid)) begin
            r_m_valid <= 1'b1;
            r_m_data  <= s_tdata;
            r_m_keep  <= s_tkeep;
            r_m_last  <= s_tlast;
            r_m_id    <= s_tid;
            r_m_dest  <= w_dest;
        end else if (w_push) begin
            r_sk_valid <= 1'b1;
            r_sk_data  <= s_tdata;
            r_sk_keep  <= s_tkeep;
            r_sk_last  <= s_tlast;
            r_sk_id    <= s_tid;
            r_sk_dest  <= w_dest;
        end else if (w_pop) begin
            r_m_valid <= 1'b0;
        end
    end

    assign s_tready = w_s_ready;
    assign m_tvalid = r_m_valid;
    assign m_tdata  = r_m_data;
    assign m_tkeep  = r_m_keep;
    assign m_tlast  = r_m_last;
    assign m_tid    = r_m_id;
    assign m_tdest  = r_m_dest;

`ifdef DTU_ROUTE_STATS_EN
    logic [31:0] r_pkt_cnt;
    logic [15:0] r_drop_cnt;
    logic        r_route_err;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pkt_cnt   <= 32'd0;
            r_drop_cnt  <= 16'd0;
            r_route_err <= 1'b0;
        end else begin
            if (w_push && s_tlast)
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            if (w_acc && w_drop_beat && s_tlast && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;
            if (w_acc && w_drop_beat)
                r_route_err <= 1'b1;
        end
    end

    assign pkt_cnt   = r_pkt_cnt;
    assign drop_cnt  = r_drop_cnt;
    assign route_err = r_route_err;
`else
    assign pkt_cnt   = 32'd0;
    assign drop_cnt  = 16'd0;
    assign route_err = 1'b0;
`endif

endmodule

// File: tb/tb_dtu_route_tagger.sv
// tb/tb_dtu_route_tagger.sv - directed self-checking bench for dtu_route_tagger
`timescale 1ns/1ps
module tb_dtu_route_tagger;

`ifdef DTU_ROUTE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cfg_route_valid = 1'b0;
    logic [7:0]  cfg_route = 8'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] s_tdata = 32'd0;
    logic [3:0]  s_tkeep = 4'd0;
    logic        s_tlast = 1'b0;
    logic [3:0]  s_tid = 4'd0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic [3:0]  m_tid;
    logic [7:0]  m_tdest;
    logic [31:0] pkt_cnt;
    logic [15:0] drop_cnt;
    logic        route_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] rx_data[$];
    logic [7:0]  rx_dest[$];
    logic        rx_last[$];

    dtu_route_tagger #(.DATA_BITS(32), .ID_BITS(4), .N_DEST(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_route_valid(cfg_route_valid), .cfg_route(cfg_route),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .route_err(route_err)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (aresetn && m_tvalid && m_tready) begin
            rx_data.push_back(m_tdata);
            rx_dest.push_back(m_tdest);
            rx_last.push_back(m_tlast);
        end
    end

    task automatic clear_rx();
        rx_data.delete();
        rx_dest.delete();
        rx_last.delete();
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic last,
                              input logic cfg_v, input logic [7:0] cfg_r,
                              output int waited);
        bit ok = 0;
        waited = 0;
        s_tvalid = 1'b1; s_tdata = d; s_tkeep = 4'hF; s_tlast = last; s_tid = d[3:0];
        cfg_route_valid = cfg_v; cfg_route = cfg_r;
        for (int c = 0; c < 50; c++) begin
            @(negedge aclk);
            if (s_tready) begin
                @(posedge aclk); #1;
                ok = 1;
                break;
            end
            @(posedge aclk); #1;
            waited++;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; cfg_route_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL beat_accept_timeout data=%h waited=%0d required=<50", d, waited);
        end
    endtask

    task automatic set_route(input logic [7:0] r);
        cfg_route_valid = 1'b1; cfg_route = r;
        @(posedge aclk); #1;
        cfg_route_valid = 1'b0;
    endtask

    task automatic check_rx(input string name, input int n, input logic [31:0] base,
                            input logic [7:0] dest_a, input int n_a, input logic [7:0] dest_b,
                            input int last_a);
        checks++;
        if (rx_data.size() !== n) begin
            failures++;
            $display("FAIL %s_count got=%0d expected=%0d", name, rx_data.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (rx_data[i] !== base + 32'(i) || rx_dest[i] !== (i < n_a ? dest_a : dest_b) ||
                    rx_last[i] !== (i == last_a || i == n - 1)) begin
                    failures++;
                    $display("FAIL %s_beat%0d got data=%h dest=%0d last=%b expected data=%h dest=%0d last=%b",
                             name, i, rx_data[i], rx_dest[i], rx_last[i], base + 32'(i),
                             (i < n_a ? dest_a : dest_b), (i == last_a || i == n - 1));
                end
            end
        end
    endtask

    task automatic test_reset();
        #22;
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || m_tdest !== 8'd0 || m_tdata !== 32'd0 ||
            m_tlast !== 1'b0 || m_tkeep !== 4'd0 || m_tid !== 4'd0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b rdy=%b dest=%0d data=%h expected all 0",
                     m_tvalid, s_tready, m_tdest, m_tdata);
        end
        checks++;
        if (pkt_cnt !== 32'd0 || drop_cnt !== 16'd0 || route_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_stats got pkt=%0d drop=%0d err=%b expected 0", pkt_cnt, drop_cnt, route_err);
        end
        aresetn = 1'b1;
        @(posedge aclk); #1;
        checks++;
        if (s_tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b expected=1", s_tready);
        end
    endtask

    task automatic test_basic();
        int w;
        m_tready = 1'b1;
        set_route(8'd2);
        clear_rx();
        drive_beat(32'h100, 1'b0, 1'b0, 8'd0, w);
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h100 || m_tdest !== 8'd2) begin
            failures++;
            $display("FAIL basic_latency got v=%b data=%h dest=%0d expected v=1 data=00000100 dest=2",
                     m_tvalid, m_tdata, m_tdest);
        end
        for (int i = 1; i < 4; i++) drive_beat(32'h100 + 32'(i), i == 3, 1'b0, 8'd0, w);
        repeat (4) @(posedge aclk); #1;
        check_rx("basic", 4, 32'h100, 8'd2, 4, 8'd2, 3);
        checks++;
        if (pkt_cnt !== (STATS ? 32'd1 : 32'd0)) begin
            failures++;
            $display("FAIL basic_pkt_cnt got=%0d expected=%0d", pkt_cnt, STATS ? 1 : 0);
        end
    endtask

    task automatic test_route_change();
        int w;
        set_route(8'd1);
        clear_rx();
        for (int i = 0; i < 5; i++) drive_beat(32'h200 + 32'(i), i == 4, i == 1, 8'd3, w);
        for (int i = 5; i < 7; i++) drive_beat(32'h200 + 32'(i), i == 6, 1'b0, 8'd0, w);
        repeat (4) @(posedge aclk); #1;
        check_rx("route_change", 7, 32'h200, 8'd1, 5, 8'd3, 4);
        checks++;
        if (pkt_cnt !== (STATS ? 32'd3 : 32'd0)) begin
            failures++;
            $display("FAIL route_change_pkt_cnt got=%0d expected=%0d", pkt_cnt, STATS ? 3 : 0);
        end
    endtask

    task automatic test_drop();
        int w;
        set_route(8'd9);
        clear_rx();
        for (int i = 0; i < 3; i++) begin
            drive_beat(32'h300 + 32'(i), i == 2, 1'b0, 8'd0, w);
            checks++;
            if (w !== 0) begin
                failures++;
                $display("FAIL drop_ready_beat%0d got wait=%0d expected=0", i, w);
            end
        end
        drive_beat(32'h303, 1'b1, 1'b0, 8'd0, w);
        repeat (3) @(posedge aclk); #1;
        checks++;
        if (rx_data.size() !== 0 || m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL drop_no_output got beats=%0d v=%b expected 0", rx_data.size(), m_tvalid);
        end
        checks++;
        if (drop_cnt !== (STATS ? 16'd2 : 16'd0) || route_err !== STATS) begin
            failures++;
            $display("FAIL drop_stats got drop=%0d err=%b expected drop=%0d err=%b",
                     drop_cnt, route_err, STATS ? 2 : 0, STATS);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        set_route(8'd3);
        clear_rx();
        m_tready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_beat(32'h400 + 32'(i), 1'b0, 1'b0, 8'd0, w);
            checks++;
            if (w !== 0) begin
                failures++;
                $display("FAIL bp_fill_beat%0d got wait=%0d expected=0", i, w);
            end
        end
        s_tvalid = 1'b1; s_tdata = 32'h402; s_tkeep = 4'hF; s_tlast = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            checks++;
            if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== 32'h400 ||
                m_tdest !== 8'd3 || m_tlast !== 1'b0) begin
                failures++;
                $display("FAIL bp_stall_cycle%0d got rdy=%b v=%b data=%h dest=%0d expected rdy=0 v=1 data=00000400 dest=3",
                         c, s_tready, m_tvalid, m_tdata, m_tdest);
            end
            @(posedge aclk); #1;
        end
        m_tready = 1'b1;
        for (int i = 2; i < 8; i++) drive_beat(32'h400 + 32'(i), i == 7, 1'b0, 8'd0, w);
        repeat (4) @(posedge aclk); #1;
        check_rx("backpressure", 8, 32'h400, 8'd3, 8, 8'd3, 7);
    endtask

    task automatic test_reset_mid();
        int w;
        set_route(8'd2);
        for (int i = 0; i < 3; i++) drive_beat(32'h500 + 32'(i), 1'b0, 1'b0, 8'd0, w);
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || m_tdest !== 8'd0 || m_tdata !== 32'd0 ||
            pkt_cnt !== 32'd0 || drop_cnt !== 16'd0 || route_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs got v=%b rdy=%b dest=%0d data=%h pkt=%0d drop=%0d err=%b expected all 0",
                     m_tvalid, s_tready, m_tdest, m_tdata, pkt_cnt, drop_cnt, route_err);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        clear_rx();
        for (int i = 0; i < 2; i++) drive_beat(32'h600 + 32'(i), i == 1, 1'b0, 8'd0, w);
        repeat (4) @(posedge aclk); #1;
        check_rx("post_reset", 2, 32'h600, 8'd0, 2, 8'd0, 1);
        checks++;
        if (pkt_cnt !== (STATS ? 32'd1 : 32'd0)) begin
            failures++;
            $display("FAIL post_reset_pkt_cnt got=%0d expected=%0d", pkt_cnt, STATS ? 1 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_route_change();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
